// File: rtl/eh2_ifu_expand_align.sv
// Fetch-packet aligner and RVC expander between the IFU fetch buffer and decode.
// Packets of FETCH_HW halfwords are written into a circular halfword queue; each
// cycle up to NOUT in-order instructions are presented, expanded to 32 bits.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   flush         discard all queued halfwords, reload PC from the next packet
//   fetch_*       packet handshake (valid/ready), data, PC[31:1], first valid halfword
//   out_valid     per-lane valid (thermometer)
//   out_instr     expanded instruction per lane (raw encoding when illegal)
//   out_pc        PC[31:1] per lane
//   out_is16      lane came from a compressed encoding
//   out_illegal   encoding illegal (lane still valid)
//   out_take      decode consumes lanes (thermometer, subset of out_valid)
module eh2_ifu_expand_align #(
  parameter int FETCH_HW = 4,
  parameter int DEPTH    = 12,
  parameter int NOUT     = 2,
  parameter int RVC_EN   = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          flush,
  input  logic                          fetch_valid,
  output logic                          fetch_ready,
  input  logic [16*FETCH_HW-1:0]        fetch_data,
  input  logic [30:0]                   fetch_pc,
  input  logic [$clog2(FETCH_HW)-1:0]   fetch_start,
  output logic [NOUT-1:0]               out_valid,
  output logic [32*NOUT-1:0]            out_instr,
  output logic [31*NOUT-1:0]            out_pc,
  output logic [NOUT-1:0]               out_is16,
  output logic [NOUT-1:0]               out_illegal,
  input  logic [NOUT-1:0]               out_take
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [15:0]   q [DEPTH];
  logic [PW-1:0] head;
  logic [CW-1:0] count;
  logic [30:0]   head_pc;
  logic          pc_load;
  logic          accept;
  int            taken;
  int            enq;

  // Offsets never exceed two queue lengths, so two conditional subtracts
  // give a modulo that works for non-power-of-2 depths.
  function automatic logic [PW-1:0] wrap(input int p);
    int s;
    s = p;
    if (s >= DEPTH) s = s - DEPTH;
    if (s >= DEPTH) s = s - DEPTH;
    return PW'(s);
  endfunction

  // RV32C to RV32I expansion; returns 0 for reserved/illegal encodings.
  function automatic logic [31:0] expand16(input logic [15:0] i);
    logic [31:0] o;
    logic [6:0]  f7;
    logic [2:0]  f3;
    o  = 32'h0;
    f7 = (i[6:5] == 2'b00) ? 7'h20 : 7'h00;
    f3 = (i[6:5] == 2'b00) ? 3'b000 : (i[6:5] == 2'b01) ? 3'b100 :
         (i[6:5] == 2'b10) ? 3'b110 : 3'b111;
    case ({i[1:0], i[15:13]})
      5'b00_000: if (i[12:5] != 8'd0)
        o = {2'b0, i[10:7], i[12:11], i[5], i[6], 2'b00, 5'd2, 3'b000, 2'b01, i[4:2], 7'h13};
      5'b00_010: o = {5'b0, i[5], i[12:10], i[6], 2'b00, 2'b01, i[9:7], 3'b010, 2'b01, i[4:2], 7'h03};
      5'b00_110: o = {5'b0, i[5], i[12], 2'b01, i[4:2], 2'b01, i[9:7], 3'b010, i[11:10], i[6], 2'b00, 7'h23};
      5'b01_000: o = {{6{i[12]}}, i[12], i[6:2], i[11:7], 3'b000, i[11:7], 7'h13};
      5'b01_001: o = {i[12], i[8], i[10:9], i[6], i[7], i[2], i[11], i[5:3], i[12], {8{i[12]}}, 5'd1, 7'h6f};
      5'b01_010: o = {{6{i[12]}}, i[12], i[6:2], 5'd0, 3'b000, i[11:7], 7'h13};
      5'b01_011: begin
        if ({i[12], i[6:2]} != 6'd0) begin
          if (i[11:7] == 5'd2)
            o = {{3{i[12]}}, i[4:3], i[5], i[2], i[6], 4'b0000, 5'd2, 3'b000, 5'd2, 7'h13};
          else
            o = {{15{i[12]}}, i[6:2], i[11:7], 7'h37};
        end
      end
      5'b01_100: begin
        case (i[11:10])
          2'b00:   if (!i[12]) o = {7'h00, i[6:2], 2'b01, i[9:7], 3'b101, 2'b01, i[9:7], 7'h13};
          2'b01:   if (!i[12]) o = {7'h20, i[6:2], 2'b01, i[9:7], 3'b101, 2'b01, i[9:7], 7'h13};
          2'b10:   o = {{6{i[12]}}, i[12], i[6:2], 2'b01, i[9:7], 3'b111, 2'b01, i[9:7], 7'h13};
          default: if (!i[12]) o = {f7, 2'b01, i[4:2], 2'b01, i[9:7], f3, 2'b01, i[9:7], 7'h33};
        endcase
      end
      5'b01_101: o = {i[12], i[8], i[10:9], i[6], i[7], i[2], i[11], i[5:3], i[12], {8{i[12]}}, 5'd0, 7'h6f};
      5'b01_110, 5'b01_111:
        o = {i[12], {3{i[12]}}, i[6:5], i[2], 5'd0, 2'b01, i[9:7], 2'b00, i[13], i[11:10], i[4:3], i[12], 7'h63};
      5'b10_000: if (!i[12]) o = {7'h00, i[6:2], i[11:7], 3'b001, i[11:7], 7'h13};
      5'b10_010: if (i[11:7] != 5'd0)
        o = {4'b0, i[3:2], i[12], i[6:4], 2'b00, 5'd2, 3'b010, i[11:7], 7'h03};
      5'b10_100: begin
        if (!i[12]) begin
          if (i[6:2] == 5'd0) begin
            if (i[11:7] != 5'd0) o = {12'h0, i[11:7], 3'b000, 5'd0, 7'h67};
          end else begin
            o = {7'h00, i[6:2], 5'd0, 3'b000, i[11:7], 7'h33};
          end
        end else begin
          if (i[11:2] == 10'd0)     o = 32'h0010_0073;
          else if (i[6:2] == 5'd0)  o = {12'h0, i[11:7], 3'b000, 5'd1, 7'h67};
          else                      o = {7'h00, i[6:2], i[11:7], 3'b000, i[11:7], 7'h33};
        end
      end
      5'b10_110: o = {4'b0, i[8:7], i[12], i[6:2], 5'd2, 3'b010, i[11:9], 2'b00, 7'h23};
      default:   o = 32'h0;
    endcase
    return o;
  endfunction

  // Ready depends on the registered count only, so decode's take never
  // feeds back into the fetch handshake within a cycle.
  assign fetch_ready = int'(count) <= (DEPTH - FETCH_HW);
  assign accept      = fetch_valid & fetch_ready & ~flush;
  assign enq         = accept ? (FETCH_HW - int'(fetch_start)) : 0;

  // Lane formation: each lane starts right after the previous one; a lane
  // that is not fully queued breaks the valid chain for all later lanes.
  always_comb begin
    int          off;
    logic        chain;
    logic        is32;
    logic        ill;
    logic [15:0] lo;
    logic [15:0] hi;
    logic [31:0] ex;
    off         = 0;
    chain       = 1'b1;
    is32        = 1'b0;
    ill         = 1'b0;
    lo          = 16'h0;
    hi          = 16'h0;
    ex          = 32'h0;
    taken       = 0;
    out_valid   = '0;
    out_instr   = '0;
    out_pc      = '0;
    out_is16    = '0;
    out_illegal = '0;
    for (int k = 0; k < NOUT; k++) begin
      lo    = q[wrap(int'(head) + off)];
      hi    = q[wrap(int'(head) + off + 1)];
      is32  = (lo[1:0] == 2'b11);
      ex    = (RVC_EN != 0) ? expand16(lo) : 32'h0;
      ill   = !is32 && (ex == 32'h0);
      chain = chain && (int'(count) >= off + (is32 ? 2 : 1));
      out_valid[k]          = chain;
      out_is16[k]           = !is32;
      out_illegal[k]        = ill;
      out_instr[32*k +: 32] = is32 ? {hi, lo} : (ill ? {16'h0, lo} : ex);
      out_pc[31*k +: 31]    = head_pc + 31'(off);
      if (chain && out_take[k]) taken = taken + (is32 ? 2 : 1);
      off = off + (is32 ? 2 : 1);
    end
  end

  // Queue storage: halfwords fetch_start.. land at the tail in order.
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int j = 0; j < FETCH_HW; j++) begin
        if (j >= int'(fetch_start))
          q[wrap(int'(head) + int'(count) + j - int'(fetch_start))] <= fetch_data[16*j +: 16];
      end
    end
  end

  // Queue control: flush outranks both take and accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      count   <= '0;
      head    <= '0;
      head_pc <= '0;
      pc_load <= 1'b1;
    end else if (flush) begin
      count   <= '0;
      pc_load <= 1'b1;
    end else begin
      count <= CW'(int'(count) - taken + enq);
      head  <= wrap(int'(head) + taken);
      // With pc_load set the queue is empty, so nothing can be taken.
      if (accept && pc_load) head_pc <= fetch_pc + 31'(fetch_start);
      else                   head_pc <= head_pc + 31'(taken);
      if (accept) pc_load <= 1'b0;
    end
  end
endmodule

// File: tb/tb_eh2_ifu_expand_align.sv
module tb_eh2_ifu_expand_align;
  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        fetch_valid;
  logic        fetch_ready, ready2;
  logic [63:0] fetch_data;
  logic [30:0] fetch_pc;
  logic [1:0]  fetch_start;
  logic [1:0]  out_valid, valid2;
  logic [63:0] out_instr, instr2;
  logic [61:0] out_pc, pc2;
  logic [1:0]  out_is16, is16_2;
  logic [1:0]  out_illegal, ill2;
  logic [1:0]  out_take;

  typedef struct {
    logic [31:0] instr;
    logic [30:0] pc;
    logic        is16;
    logic        ill;
  } exp_t;

  exp_t        sb[$];
  logic [30:0] exp_pc;
  logic [63:0] d;
  int          n_cmp = 0;
  int          n_err = 0;

  eh2_ifu_expand_align #(.FETCH_HW(4), .DEPTH(12), .NOUT(2), .RVC_EN(1)) dut (
    .clk(clk), .rst(rst), .flush(flush), .fetch_valid(fetch_valid),
    .fetch_ready(fetch_ready), .fetch_data(fetch_data), .fetch_pc(fetch_pc),
    .fetch_start(fetch_start), .out_valid(out_valid), .out_instr(out_instr),
    .out_pc(out_pc), .out_is16(out_is16), .out_illegal(out_illegal),
    .out_take(out_take));

  eh2_ifu_expand_align #(.FETCH_HW(4), .DEPTH(12), .NOUT(2), .RVC_EN(0)) dut_norvc (
    .clk(clk), .rst(rst), .flush(flush), .fetch_valid(fetch_valid),
    .fetch_ready(ready2), .fetch_data(fetch_data), .fetch_pc(fetch_pc),
    .fetch_start(fetch_start), .out_valid(valid2), .out_instr(instr2),
    .out_pc(pc2), .out_is16(is16_2), .out_illegal(ill2),
    .out_take(out_take));

  always #5 clk = ~clk;

  function automatic void check(string nm, logic [31:0] act, logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, req);
    end
  endfunction

  function automatic logic [15:0] enc(int n);
    return 16'h0081 | 16'(n << 2);
  endfunction

  function automatic logic [31:0] addi(int n);
    return (32'(n) << 20) | 32'h0000_8093;
  endfunction

  task automatic push(input logic [31:0] ins, input logic is16, input logic ill);
    exp_t e;
    e.instr = ins;
    e.pc    = exp_pc;
    e.is16  = is16;
    e.ill   = ill;
    sb.push_back(e);
    exp_pc = exp_pc + (is16 ? 31'd1 : 31'd2);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [63:0] dat, input logic [30:0] pc, input logic [1:0] st);
    fetch_data  = dat;
    fetch_pc    = pc;
    fetch_start = st;
    fetch_valid = 1'b1;
    tick();
    fetch_valid = 1'b0;
  endtask

  task automatic take(input logic [1:0] t);
    out_take = t;
    tick();
    out_take = 2'b00;
  endtask

  // Monitor: every lane decode consumes is popped from the scoreboard.
  always @(negedge clk) begin
    if (!rst && !flush) begin
      for (int k = 0; k < 2; k++) begin
        if (out_take[k]) begin
          if (!out_valid[k]) begin
            n_cmp++; n_err++;
            $display("FAIL take_on_invalid lane %0d: out_valid=%b", k, out_valid);
          end else if (sb.size() == 0) begin
            n_cmp++; n_err++;
            $display("FAIL sb_empty lane %0d: got instr %h with nothing expected", k, out_instr[32*k +: 32]);
          end else begin
            exp_t e;
            e = sb.pop_front();
            check("lane_instr", out_instr[32*k +: 32], e.instr);
            check("lane_pc",    32'(out_pc[31*k +: 31]), 32'(e.pc));
            check("lane_is16",  32'(out_is16[k]), 32'(e.is16));
            check("lane_ill",   32'(out_illegal[k]), 32'(e.ill));
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; flush = 1'b0; fetch_valid = 1'b0; fetch_data = '0;
    fetch_pc = '0; fetch_start = '0; out_take = '0; exp_pc = '0;
    tick(); tick();
    check("rst_valid_in", 32'(out_valid), 32'h0);
    rst = 1'b0;
    tick();
    check("rst_valid", 32'(out_valid), 32'h0);
    check("rst_ready", 32'(fetch_ready), 32'h1);

    // Basic expansion and consume
    exp_pc = 31'h20;
    push(32'h0010_8093, 1, 0); push(32'h0000_0013, 1, 0);
    push(32'h00B0_0533, 1, 0); push(32'h0000_0013, 1, 0);
    send({16'h0001, 16'h852E, 16'h0001, 16'h0085}, 31'h20, 2'd0);
    check("t2_valid", 32'(out_valid), 32'h3);
    check("t2_norvc_ill", 32'(ill2[0]), 32'h1);
    check("t2_norvc_raw", instr2[31:0], 32'h0000_0085);
    take(2'b11);
    check("t2_valid2", 32'(out_valid), 32'h3);
    take(2'b11);
    check("t2_empty", 32'(out_valid), 32'h0);

    // Straddling 32b instruction; fetch_pc ignored once loaded
    push(32'h13, 1, 0); push(32'h13, 1, 0); push(32'h13, 1, 0);
    push(32'h0010_8093, 0, 0);
    send({16'h8093, 16'h0001, 16'h0001, 16'h0001}, 31'h7777, 2'd0);
    check("t3_valid", 32'(out_valid), 32'h3);
    take(2'b01);
    check("t3_valid1", 32'(out_valid), 32'h3);
    take(2'b11);
    check("t3_half_wait", 32'(out_valid), 32'h0);
    tick();
    check("t3_half_wait2", 32'(out_valid), 32'h0);
    push(32'h13, 1, 0); push(32'h13, 1, 0); push(32'h13, 1, 0);
    send({16'h0001, 16'h0001, 16'h0001, 16'h0010}, 31'h555, 2'd0);
    check("t3_join_valid", 32'(out_valid), 32'h3);
    check("t3_join_is16", 32'(out_is16), 32'h2);
    take(2'b11);
    take(2'b11);
    check("t3_empty", 32'(out_valid), 32'h0);

    // Flush beats take and fetch in the same cycle; fetch_start skips halfwords
    send({4{16'h0001}}, 31'h0, 2'd0);
    flush = 1'b1; fetch_valid = 1'b1; fetch_data = {4{16'h0085}}; out_take = 2'b11;
    tick();
    flush = 1'b0; fetch_valid = 1'b0; out_take = 2'b00;
    check("t4_flush_valid", 32'(out_valid), 32'h0);
    check("t4_flush_ready", 32'(fetch_ready), 32'h1);
    tick();
    check("t4_drop", 32'(out_valid), 32'h0);
    exp_pc = 31'h82;
    push(32'h0010_8093, 1, 0); push(32'h13, 1, 0);
    send({16'h0001, 16'h0085, 16'h1111, 16'h1111}, 31'h80, 2'd2);
    check("t4_valid", 32'(out_valid), 32'h3);
    take(2'b11);
    check("t4_empty", 32'(out_valid), 32'h0);

    // Backpressure and queue wrap
    for (int p = 0; p < 2; p++) begin
      for (int h = 0; h < 4; h++) begin
        d[16*h +: 16] = enc(4*p + h + 1);
        push(addi(4*p + h + 1), 1, 0);
      end
      send(d, 31'h0, 2'd0);
    end
    check("t5_ready8", 32'(fetch_ready), 32'h1);
    push(addi(9), 1, 0);
    send({enc(9), 48'h0}, 31'h0, 2'd3);
    check("t5_ready9", 32'(fetch_ready), 32'h0);
    for (int h = 0; h < 4; h++) d[16*h +: 16] = enc(10 + h);
    fetch_data = d; fetch_start = 2'd0; fetch_valid = 1'b1;
    tick();
    check("t5_hold_a", 32'(fetch_ready), 32'h0);
    tick();
    check("t5_hold_b", 32'(fetch_ready), 32'h0);
    for (int h = 0; h < 4; h++) push(addi(10 + h), 1, 0);
    take(2'b01);
    check("t5_ready_after_take", 32'(fetch_ready), 32'h1);
    tick();
    fetch_valid = 1'b0;
    check("t5_full", 32'(fetch_ready), 32'h0);
    for (int r = 0; r < 6; r++) take(2'b11);
    check("t5_empty", 32'(out_valid), 32'h0);

    // Illegal encodings, with and without RVC
    push(32'h0, 1, 1); push(32'h0000_4002, 1, 1);
    push(32'h13, 1, 0); push(32'h13, 1, 0);
    send({16'h0001, 16'h0001, 16'h4002, 16'h0000}, 31'h0, 2'd0);
    check("t6_valid", 32'(out_valid), 32'h3);
    check("t6_ill", 32'(out_illegal), 32'h3);
    check("t6_norvc_valid", 32'(valid2), 32'h3);
    check("t6_norvc_ill", 32'(ill2), 32'h3);
    check("t6_norvc_is16", 32'(is16_2), 32'h3);
    check("t6_norvc_pc1", 32'(pc2[61:31]), 32'(sb[1].pc));
    check("t6_norvc_ready", 32'(ready2), 32'h1);
    take(2'b11);
    check("t6_norvc_nop_ill", 32'(ill2), 32'h3);
    take(2'b11);
    check("t6_empty", 32'(out_valid), 32'h0);

    // Reset mid-operation, then PC reload
    send({4{16'h0001}}, 31'h0, 2'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t7_rst_valid", 32'(out_valid), 32'h0);
    check("t7_rst_ready", 32'(fetch_ready), 32'h1);
    exp_pc = 31'h800;
    push(addi(5), 1, 0); push(addi(6), 1, 0); push(addi(7), 1, 0); push(addi(8), 1, 0);
    send({enc(8), enc(7), enc(6), enc(5)}, 31'h800, 2'd0);
    take(2'b11);
    take(2'b11);
    check("t7_empty", 32'(out_valid), 32'h0);

    check("sb_leftover", 32'(sb.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/eh2_ifu_expand_align.md
Name: eh2_ifu_expand_align

Overview:
Parametrised fetch-packet aligner and RVC expander between the IFU fetch buffer and decode. It accepts packets of FETCH_HW halfwords and holds them in a halfword queue. Each cycle it presents up to NOUT in-order instructions, fully expanded to 32b, with PC, size and illegal flags. It handles 32b instructions that straddle packets, mid-packet branch targets and pipeline flushes.

Parameters:
FETCH_HW, 4, halfwords per fetch packet (power of 2, 2..8)
DEPTH, 12, queue capacity in halfwords (>= 2*FETCH_HW)
NOUT, 2, output lanes per cycle (1..4)
RVC_EN, 1, 1 = expand compressed encodings; 0 = every 16b encoding is illegal

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
flush  in  1  discard all queued and in-flight halfwords
fetch_valid  in  1  fetch packet present
fetch_ready  out  1  queue can accept a full packet this cycle
fetch_data  in  16*FETCH_HW  packet; halfword 0 in bits [15:0]
fetch_pc  in  31  PC[31:1] of halfword 0 of the packet
fetch_start  in  log2(FETCH_HW)  index of the first valid halfword
out_valid  out  NOUT  per-lane valid, thermometer (lane k valid implies lanes <k valid)
out_instr  out  32*NOUT  expanded instruction; illegal lanes carry {16'b0, raw16} or the raw 32b word
out_pc  out  31*NOUT  PC[31:1] of each lane
out_is16  out  NOUT  lane came from a 16b encoding
out_illegal  out  NOUT  encoding illegal
out_take  in  NOUT  decode consumes lanes; thermometer and a subset of out_valid

Behaviour:
- State:
  - Circular halfword queue (DEPTH entries), head pointer, count (0..DEPTH).
  - head_pc[31:1].
  - pc_load flag: set by reset or flush, cleared by the first accepted packet.
- Reset: count=0, head=0, head_pc=0, pc_load=1. All out_valid=0. fetch_ready=1 from the first cycle after reset.
- fetch_ready = (DEPTH - count) >= FETCH_HW, using the registered count only (no dependency on out_take).
- Accept condition: fetch_valid & fetch_ready & !flush.
  - Enqueue halfwords fetch_start..FETCH_HW-1 in order.
  - If pc_load=1: head_pc <= fetch_pc + fetch_start and clear pc_load. Otherwise fetch_pc is ignored, because packets are sequential.
- Latency: an accepted packet is visible on the out_* ports the next cycle. Outputs are combinational from queue state.
- Lane formation, lane 0 at head, lane k directly after lane k-1:
  - hw[1:0] != 2'b11: 16b lane. Expanded by the team's 16b->32b expander, one instance per lane. out_is16=1.
  - hw[1:0] == 2'b11: 32b lane, taking two halfwords {hw+1, hw}. out_is16=0, instruction passed unchanged.
  - A lane is valid only if all of its halfwords are queued. A 32b lane whose second half is not yet queued is invalid, and so are all later lanes.
  - out_pc of lane k = head_pc + halfwords used by lanes 0..k-1, mod 2^31.
- Illegal: a 16b lane is illegal when the expander returns 0, and 16'h0000 is always illegal. If RVC_EN=0, every 16b lane is illegal. An illegal lane is still valid; decode traps on it.
- Consume: on the clock edge, head, count and head_pc advance by the halfwords of all taken lanes.
- Simultaneous take + accept is legal. New count = count - taken + enqueued, which never exceeds DEPTH.
- Head and tail pointers wrap modulo DEPTH; DEPTH need not be a power of 2.
- Flush:
  - Takes priority over take and fetch in the same cycle.
  - count <= 0, pc_load <= 1, out_valid = 0 from the next cycle.
  - A fetch presented in the flush cycle is dropped.
- rst mid-operation behaves exactly like reset; queue contents need not be cleared.
- out_take that is non-thermometer or exceeds out_valid is illegal. The verification bench asserts against it; the RTL behaviour is undefined.

Test Plan:
- Reset, then packet {0x0085, 0x0001, 0x852E, 0x0001}, fetch_pc=0x40>>1, start=0, NOUT=2 -> next cycle lane0 = 0x00108093 @0x40 and lane1 = 0x00000013 @0x42, both is16. Take both -> next lanes 0x00B00533 @0x44 and 0x00000013 @0x46.
- Straddle: packet with 0x0001 x3, then halfword 3 = 0x8093 (low half of 0x00108093); out_take held 0 -> lanes show the three c.nops, and the 32b lane is invalid until the next packet supplies 0x0010. It then appears as 0x00108093, is16=0, at PC packet+6.
- fetch_start=2 after flush, fetch_pc=0x100>>1 -> lane0 PC = 0x104; halfwords 0-1 never appear.
- Fill to count > DEPTH-FETCH_HW with no take -> fetch_ready=0 and a held fetch_valid is not enqueued. Take one lane -> fetch_ready=1 the next cycle. Queue wrap is exercised with no lost or duplicated halfwords.
- Raw 0x0000 and reserved c.lwsp with rd=0 (0x4002) -> valid lanes with out_illegal=1 and out_instr=0x00000000 and 0x00004002. Repeat with RVC_EN=0 -> 0x0085 is flagged illegal.
- flush together with fetch_valid and out_take -> next cycle out_valid=0 and count=0. The next accepted packet reloads head_pc from its fetch_pc.
